// File: rtl/ddr_clk_align_ctrl_if.sv
// Control and status bundle between the DDR clock-alignment controller and the
// phase detector, PLL dynamic-phase port and edge-clock/datapath reset logic.
interface ddr_clk_align_ctrl_if #(
    parameter int PHASE_W = 4
);
    logic               lock;
    logic               start;
    logic               scan_en;
    logic [1:0]         status_raw;
    logic [PHASE_W-1:0] phase;
    logic               stop;
    logic               reset_datapath_out;
    logic               busy;
    logic               good;
    logic               err;
    logic [PHASE_W-1:0] win_lo;
    logic [PHASE_W-1:0] win_hi;

    modport master (
        output lock, start, scan_en, status_raw,
        input  phase, stop, reset_datapath_out, busy, good, err, win_lo, win_hi
    );

    modport slave (
        input  lock, start, scan_en, status_raw,
        output phase, stop, reset_datapath_out, busy, good, err, win_lo, win_hi
    );
endinterface

// File: rtl/ddr_clk_align_ctrl.sv
// DDR clock alignment: steps the PLL dynamic phase, resyncs the edge clock after
// each step, filters alignment status with hysteresis, optionally margin-scans.
module ddr_clk_align_ctrl #(
    parameter int PHASE_W  = 4,
    parameter int FILT_W   = 7,
    parameter int SETTLE   = 16,
    parameter int STOP_LEN = 4
) (
    input  logic                 sclk,
    input  logic                 reset,
    ddr_clk_align_ctrl_if.slave  bus
);
    localparam int N          = 1 << PHASE_W;
    localparam int SETTLE_CYC = SETTLE + (1 << FILT_W);
    localparam int TMR_W      = $clog2(SETTLE_CYC + STOP_LEN + 1);
    localparam int STEP_W     = PHASE_W + 1;
    localparam logic [FILT_W-1:0] CNT_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_LOCK, S_RESYNC, S_SETTLE, S_EVAL, S_STEP, S_CENTER, S_DONE, S_FAIL
    } state_t;

    typedef struct packed {
        logic [PHASE_W-1:0] lo;
        logic [STEP_W-1:0]  len;
    } win_t;

    state_t                   state_q, state_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic [N-1:0]             vec_q, vec_d;
    logic                     mode_q, mode_d;
    logic                     final_q, final_d;
    logic [PHASE_W-1:0]       win_lo_q, win_lo_d;
    logic [PHASE_W-1:0]       win_hi_q, win_hi_d;
    logic [1:0]               status_p0_q, status_p1_q;
    logic [1:0][FILT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]               filt_q, filt_d;
    logic                     pass;
    win_t                     win;

    function automatic logic [FILT_W-1:0] sat_step(input logic [FILT_W-1:0] c, input logic up);
        if (up) return (c == CNT_MAX) ? c : c + 1'b1;
        return (c == '0) ? c : c - 1'b1;
    endfunction

    // Longest circular run of ones; only run starts are considered, so a run that
    // wraps N-1 -> 0 is indexed by its start and ties keep the lowest start.
    function automatic win_t find_win(input logic [N-1:0] v);
        win_t              best;
        logic [STEP_W-1:0] run;
        logic              open;
        best = '0;
        for (int s = 0; s < N; s++) begin
            if (v[s] && !v[(s + N - 1) % N]) begin
                run  = '0;
                open = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (open && v[(s + k) % N]) run = run + 1'b1;
                    else open = 1'b0;
                end
                if (run > best.len) begin
                    best.lo  = PHASE_W'(s);
                    best.len = run;
                end
            end
        end
        return best;
    endfunction

    assign pass = (filt_q == 2'b01);

    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (state_q == S_RESYNC) begin
            cnt_d  = '0;
            filt_d = '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                cnt_d[b] = sat_step(cnt_q[b], status_p1_q[b]);
                if (cnt_d[b] == CNT_MAX) filt_d[b] = 1'b1;
                else if (cnt_d[b] == '0) filt_d[b] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        phase_d  = phase_q;
        step_d   = step_q;
        vec_d    = vec_q;
        mode_d   = mode_q;
        final_d  = final_q;
        win_lo_d = win_lo_q;
        win_hi_d = win_hi_q;
        win      = find_win(vec_q);

        case (state_q)
            S_WAIT_LOCK: if (bus.lock) state_d = S_RESYNC;
            S_RESYNC: begin
                if (tmr_q == TMR_W'(STOP_LEN - 1)) begin
                    state_d = S_SETTLE;
                    tmr_d   = '0;
                end else tmr_d = tmr_q + 1'b1;
            end
            S_SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
                    state_d = final_q ? S_DONE : S_EVAL;
                    tmr_d   = '0;
                end else tmr_d = tmr_q + 1'b1;
            end
            S_EVAL: begin
                if (mode_q) begin
                    vec_d[phase_q] = pass;
                    state_d        = S_STEP;
                end else state_d = pass ? S_DONE : S_STEP;
            end
            S_STEP: begin
                phase_d = phase_q + 1'b1;
                step_d  = step_q + 1'b1;
                tmr_d   = '0;
                if (step_d == STEP_W'(N)) state_d = mode_q ? S_CENTER : S_FAIL;
                else state_d = S_RESYNC;
            end
            S_CENTER: begin
                if (vec_q == '0) state_d = S_FAIL;
                else begin
                    final_d = 1'b1;
                    tmr_d   = '0;
                    state_d = S_RESYNC;
                    if (&vec_q) begin
                        win_lo_d = '0;
                        win_hi_d = '1;
                        phase_d  = PHASE_W'(N / 2);
                    end else begin
                        win_lo_d = win.lo;
                        win_hi_d = win.lo + PHASE_W'(win.len - 1'b1);
                        phase_d  = win.lo + PHASE_W'(win.len >> 1);
                    end
                end
            end
            default: ;
        endcase

        if (bus.start && (state_q inside {S_IDLE, S_DONE, S_FAIL})) begin
            mode_d  = bus.scan_en;
            state_d = S_WAIT_LOCK;
        end
        // Lock loss restarts the latched mode from wherever the phase currently is.
        if (!bus.lock && !(state_q inside {S_IDLE, S_FAIL})) begin
            state_d  = S_WAIT_LOCK;
            phase_d  = phase_q;
            win_lo_d = win_lo_q;
            win_hi_d = win_hi_q;
        end
        if (state_d == S_WAIT_LOCK) begin
            step_d  = '0;
            vec_d   = '0;
            final_d = 1'b0;
            tmr_d   = '0;
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            phase_q     <= '0;
            step_q      <= '0;
            vec_q       <= '0;
            mode_q      <= 1'b0;
            final_q     <= 1'b0;
            win_lo_q    <= '0;
            win_hi_q    <= '0;
            status_p0_q <= '0;
            status_p1_q <= '0;
            cnt_q       <= '0;
            filt_q      <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            phase_q     <= phase_d;
            step_q      <= step_d;
            vec_q       <= vec_d;
            mode_q      <= mode_d;
            final_q     <= final_d;
            win_lo_q    <= win_lo_d;
            win_hi_q    <= win_hi_d;
            status_p0_q <= bus.status_raw;
            status_p1_q <= status_p0_q;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
        end
    end

    // Datapath reset outlasts stop by two cycles, spilling into the settle wait.
    assign bus.phase              = phase_q;
    assign bus.stop               = (state_q == S_RESYNC);
    assign bus.reset_datapath_out = (state_q == S_RESYNC) ||
                                    ((state_q == S_SETTLE) && (tmr_q < TMR_W'(2)));
    assign bus.busy               = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
    assign bus.good               = (state_q == S_DONE);
    assign bus.err                = (state_q == S_FAIL);
    assign bus.win_lo             = win_lo_q;
    assign bus.win_hi             = win_hi_q;
endmodule

// File: tb/tb_ddr_clk_align_ctrl.sv
// Bench for ddr_clk_align_ctrl: a per-phase status table drives the detector input and
// a phase-level model predicts final phase, flags, window and resync count.
module tb_ddr_clk_align_ctrl;
    localparam int PHASE_W    = 4;
    localparam int N          = 1 << PHASE_W;
    localparam int FILT_W     = 7;
    localparam int SETTLE     = 16;
    localparam int STOP_LEN   = 4;
    localparam int RUN_BUDGET = 4000;

    logic sclk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   exp_phase = 0;

    logic [1:0] st_tab [N];
    logic       toggle0 = 1'b0;

    int n_resync = 0;
    int n_stop_bad = 0;
    int n_rdp_bad = 0;
    int n_align_bad = 0;

    always #5 sclk = ~sclk;

    ddr_clk_align_ctrl_if #(.PHASE_W(PHASE_W)) bus ();

    ddr_clk_align_ctrl #(
        .PHASE_W(PHASE_W), .FILT_W(FILT_W), .SETTLE(SETTLE), .STOP_LEN(STOP_LEN)
    ) dut (
        .sclk(sclk), .reset(reset), .bus(bus)
    );

    // Phase detector stand-in: status follows the current phase code.
    initial begin
        bus.status_raw = 2'b00;
        forever begin
            @(negedge sclk);
            if (toggle0 && bus.phase == '0) bus.status_raw = {1'b0, 1'($urandom_range(0, 1))};
            else bus.status_raw = st_tab[bus.phase];
        end
    end

    // Resync pulse monitor: counts resyncs and pulse-shape violations.
    initial begin
        int   slen, rlen;
        logic sp, rp;
        slen = 0; rlen = 0; sp = 1'b0; rp = 1'b0;
        forever begin
            @(posedge sclk); #1;
            if (bus.stop && !sp) begin
                n_resync++;
                if (!bus.reset_datapath_out || rp) n_align_bad++;
            end
            if (bus.stop) slen++;
            else if (sp) begin
                if (slen != STOP_LEN) n_stop_bad++;
                slen = 0;
            end
            if (bus.reset_datapath_out) rlen++;
            else if (rp) begin
                if (rlen != STOP_LEN + 2) n_rdp_bad++;
                rlen = 0;
            end
            sp = bus.stop;
            rp = bus.reset_datapath_out;
        end
    end

    function automatic int model_first(input logic [N-1:0] m, input int p0);
        int hit = -1;
        for (int k = N - 1; k >= 0; k--) if (m[(p0 + k) % N]) hit = k;
        return hit;
    endfunction

    // Widest all-ones circular window; among equal widths the lowest start index.
    task automatic model_scan(input logic [N-1:0] m, output logic ok,
                              output int lo, output int hi, output int ph);
        int   best_len;
        logic win_ok;
        best_len = 0;
        ok = (m != '0); lo = 0; hi = N - 1; ph = N / 2;
        if (ok && m != '1) begin
            for (int len = 1; len < N; len++) begin
                for (int s = N - 1; s >= 0; s--) begin
                    win_ok = 1'b1;
                    for (int j = 0; j < len; j++) if (!m[(s + j) % N]) win_ok = 1'b0;
                    if (win_ok) begin
                        best_len = len;
                        lo = s;
                    end
                end
            end
            hi = (lo + best_len - 1) % N;
            ph = (lo + best_len / 2) % N;
        end
    endtask

    task automatic set_mask(input logic [N-1:0] m);
        int r;
        for (int p = 0; p < N; p++) begin
            r = $urandom_range(0, 2);
            if (m[p]) st_tab[p] = 2'b01;
            else st_tab[p] = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
        end
    endtask

    task automatic apply_reset();
        @(negedge sclk);
        reset = 1'b1;
        repeat (2) @(negedge sclk);
        reset = 1'b0;
        exp_phase = 0;
        @(negedge sclk);
    endtask

    task automatic start_run(input logic scan);
        @(negedge sclk);
        bus.start = 1'b1;
        bus.scan_en = scan;
        @(negedge sclk);
        bus.start = 1'b0;
        bus.scan_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (bus.busy && c < RUN_BUDGET) begin
            @(negedge sclk);
            c++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s.timeout busy=%0b after %0d cycles, want 0", tag, bus.busy, c);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.phase !== '0) begin errors++; $display("FAIL reset.phase got=%0d want=0", bus.phase); end
        checks++;
        if ({bus.stop, bus.reset_datapath_out, bus.busy, bus.good, bus.err} !== 5'b0) begin
            errors++;
            $display("FAIL reset.flags got=%b want=00000",
                     {bus.stop, bus.reset_datapath_out, bus.busy, bus.good, bus.err});
        end
        checks++;
        if ({bus.win_lo, bus.win_hi} !== '0) begin
            errors++; $display("FAIL reset.win got=%0d/%0d want=0/0", bus.win_lo, bus.win_hi);
        end
    endtask

    task automatic test_first_pass();
        logic [N-1:0] m;
        int r0, sb0, rb0, ab0;
        m = '0; m[5] = 1'b1;
        set_mask(m);
        bus.lock = 1'b1;
        r0 = n_resync; sb0 = n_stop_bad; rb0 = n_rdp_bad; ab0 = n_align_bad;
        start_run(1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL first_pass.busy got=%0b want=1", bus.busy); end
        repeat (30) @(negedge sclk);
        bus.start = 1'b1; bus.scan_en = 1'b1;
        @(negedge sclk);
        bus.start = 1'b0; bus.scan_en = 1'b0;
        wait_idle("first_pass");
        checks++;
        if (bus.phase !== 4'd5) begin errors++; $display("FAIL first_pass.phase got=%0d want=5", bus.phase); end
        checks++;
        if ({bus.good, bus.err} !== 2'b10) begin
            errors++; $display("FAIL first_pass.good_err got=%b want=10", {bus.good, bus.err});
        end
        checks++;
        if (n_resync - r0 != 6) begin
            errors++; $display("FAIL first_pass.resyncs got=%0d want=6", n_resync - r0);
        end
        checks++;
        if ((n_stop_bad - sb0) + (n_rdp_bad - rb0) + (n_align_bad - ab0) != 0) begin
            errors++;
            $display("FAIL first_pass.pulse_shape stop_bad=%0d rdp_bad=%0d align_bad=%0d want all 0",
                     n_stop_bad - sb0, n_rdp_bad - rb0, n_align_bad - ab0);
        end
        exp_phase = 5;
    endtask

    task automatic test_rerun_from_done();
        logic [N-1:0] m;
        int r0;
        m = '0; m[8] = 1'b1;
        set_mask(m);
        r0 = n_resync;
        start_run(1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.good !== 1'b0) begin
            errors++; $display("FAIL rerun.accept busy/good got=%b%b want=10", bus.busy, bus.good);
        end
        wait_idle("rerun");
        checks++;
        if (bus.phase !== 4'd8 || bus.good !== 1'b1) begin
            errors++; $display("FAIL rerun.result phase=%0d good=%0b want phase=8 good=1", bus.phase, bus.good);
        end
        checks++;
        if (n_resync - r0 != 4) begin errors++; $display("FAIL rerun.resyncs got=%0d want=4", n_resync - r0); end
        exp_phase = 8;
    endtask

    task automatic test_hysteresis();
        int r0;
        apply_reset();
        for (int p = 0; p < N; p++) st_tab[p] = 2'b00;
        st_tab[3] = 2'b01;
        toggle0 = 1'b1;
        r0 = n_resync;
        start_run(1'b0);
        wait_idle("hysteresis");
        toggle0 = 1'b0;
        checks++;
        if (bus.phase !== 4'd3 || bus.good !== 1'b1) begin
            errors++; $display("FAIL hysteresis.result phase=%0d good=%0b want phase=3 good=1", bus.phase, bus.good);
        end
        checks++;
        if (n_resync - r0 != 4) begin errors++; $display("FAIL hysteresis.resyncs got=%0d want=4", n_resync - r0); end
        exp_phase = 3;
    endtask

    task automatic test_never_pass();
        int r0;
        apply_reset();
        for (int p = 0; p < N; p++) st_tab[p] = 2'b00;
        r0 = n_resync;
        start_run(1'b0);
        wait_idle("never_pass");
        checks++;
        if ({bus.err, bus.good, bus.busy} !== 3'b100) begin
            errors++; $display("FAIL never_pass.flags err/good/busy got=%b want=100", {bus.err, bus.good, bus.busy});
        end
        checks++;
        if (bus.phase !== 4'd0) begin errors++; $display("FAIL never_pass.phase got=%0d want=0", bus.phase); end
        checks++;
        if (n_resync - r0 != N) begin errors++; $display("FAIL never_pass.resyncs got=%0d want=%0d", n_resync - r0, N); end
        exp_phase = 0;
    endtask

    task automatic test_scan(input logic [N-1:0] m, input string tag);
        logic ok;
        int   lo, hi, ph, r0;
        model_scan(m, ok, lo, hi, ph);
        set_mask(m);
        bus.lock = 1'b1;
        r0 = n_resync;
        start_run(1'b1);
        wait_idle(tag);
        if (!ok) ph = exp_phase;
        checks++;
        if ({bus.good, bus.err} !== {ok, !ok}) begin
            errors++; $display("FAIL %s.good_err got=%b want=%b", tag, {bus.good, bus.err}, {ok, !ok});
        end
        checks++;
        if (bus.phase !== PHASE_W'(ph)) begin errors++; $display("FAIL %s.phase got=%0d want=%0d", tag, bus.phase, ph); end
        if (ok) begin
            checks++;
            if (bus.win_lo !== PHASE_W'(lo) || bus.win_hi !== PHASE_W'(hi)) begin
                errors++; $display("FAIL %s.window got=%0d..%0d want=%0d..%0d", tag, bus.win_lo, bus.win_hi, lo, hi);
            end
        end
        checks++;
        if (n_resync - r0 != (ok ? N + 1 : N)) begin
            errors++; $display("FAIL %s.resyncs got=%0d want=%0d", tag, n_resync - r0, ok ? N + 1 : N);
        end
        exp_phase = ph;
    endtask

    task automatic test_first_pass_random(input int iters);
        logic [N-1:0] m;
        int k, want_ph, r0;
        for (int i = 0; i < iters; i++) begin
            m = (i == 2) ? '0 : N'($urandom) & N'($urandom) & N'($urandom);
            set_mask(m);
            k = model_first(m, exp_phase);
            want_ph = (k < 0) ? exp_phase : (exp_phase + k) % N;
            r0 = n_resync;
            start_run(1'b0);
            wait_idle("first_rand");
            checks++;
            if (bus.phase !== PHASE_W'(want_ph) || {bus.good, bus.err} !== {k >= 0, k < 0}) begin
                errors++;
                $display("FAIL first_rand.result mask=%h phase=%0d good/err=%b want phase=%0d good/err=%b",
                         m, bus.phase, {bus.good, bus.err}, want_ph, {k >= 0, k < 0});
            end
            checks++;
            if (n_resync - r0 != ((k < 0) ? N : k + 1)) begin
                errors++; $display("FAIL first_rand.resyncs got=%0d want=%0d", n_resync - r0, (k < 0) ? N : k + 1);
            end
            exp_phase = want_ph;
        end
    endtask

    task automatic test_midrun_reset();
        set_mask(N'($urandom) | 16'h0001);
        bus.lock = 1'b1;
        start_run(1'b1);
        repeat (400) @(negedge sclk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.phase, bus.stop, bus.reset_datapath_out, bus.busy, bus.good, bus.err, bus.win_lo, bus.win_hi} !== '0) begin
            errors++;
            $display("FAIL midrun_reset.outputs phase=%0d flags=%b win=%0d/%0d want all 0", bus.phase,
                     {bus.stop, bus.reset_datapath_out, bus.busy, bus.good, bus.err}, bus.win_lo, bus.win_hi);
        end
        @(negedge sclk);
        reset = 1'b0;
        exp_phase = 0;
        repeat (3) @(negedge sclk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_reset.idle busy=%0b want=0", bus.busy); end
    endtask

    task automatic test_lock_loss();
        int c, r0;
        apply_reset();
        for (int p = 0; p < N; p++) st_tab[p] = 2'b00;
        st_tab[9] = 2'b01;
        bus.lock = 1'b1;
        start_run(1'b0);
        c = 0;
        while (bus.phase != 4'd7 && c < RUN_BUDGET) begin @(negedge sclk); c++; end
        while (!bus.stop && c < RUN_BUDGET) begin @(negedge sclk); c++; end
        while (bus.stop && c < RUN_BUDGET) begin @(negedge sclk); c++; end
        checks++;
        if (c >= RUN_BUDGET) begin errors++; $display("FAIL lock_loss.reach_settle timeout after %0d cycles", c); end
        repeat (20) @(negedge sclk);
        bus.lock = 1'b0;
        @(negedge sclk);
        checks++;
        if ({bus.good, bus.busy, bus.stop, bus.reset_datapath_out} !== 4'b0100) begin
            errors++; $display("FAIL lock_loss.abort good/busy/stop/rdp got=%b want=0100",
                               {bus.good, bus.busy, bus.stop, bus.reset_datapath_out});
        end
        repeat (2) @(negedge sclk);
        bus.lock = 1'b1;
        r0 = n_resync;
        @(negedge sclk);
        checks++;
        if (bus.stop !== 1'b1 || bus.phase !== 4'd7) begin
            errors++; $display("FAIL lock_loss.restart stop=%0b phase=%0d want stop=1 phase=7", bus.stop, bus.phase);
        end
        wait_idle("lock_loss");
        checks++;
        if (bus.phase !== 4'd9 || bus.good !== 1'b1 || n_resync - r0 != 3) begin
            errors++; $display("FAIL lock_loss.result phase=%0d good=%0b resyncs=%0d want 9/1/3",
                               bus.phase, bus.good, n_resync - r0);
        end
        bus.lock = 1'b0;
        @(negedge sclk);
        checks++;
        if (bus.good !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL lock_loss.done_drop good=%0b busy=%0b want good=0 busy=1", bus.good, bus.busy);
        end
        bus.lock = 1'b1;
        wait_idle("lock_loss_done");
        checks++;
        if (bus.phase !== 4'd9 || bus.good !== 1'b1) begin
            errors++; $display("FAIL lock_loss.relock phase=%0d good=%0b want 9/1", bus.phase, bus.good);
        end
        exp_phase = 9;
    endtask

    initial begin
        logic [N-1:0] m;
        reset = 1'b1;
        bus.lock = 1'b0;
        bus.start = 1'b0;
        bus.scan_en = 1'b0;
        for (int p = 0; p < N; p++) st_tab[p] = 2'b00;
        repeat (3) @(negedge sclk);
        test_reset();
        reset = 1'b0;
        @(negedge sclk);
        test_reset();

        test_first_pass();
        test_rerun_from_done();
        test_hysteresis();
        test_never_pass();
        test_scan(16'b1100_0000_1100_0111, "scan_wrap");
        test_scan(16'b0000_1110_0001_1100, "scan_tie");
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: m = '1;
                1: m = N'($urandom);
                2: m = N'($urandom) & N'($urandom);
                default: m = '0;
            endcase
            test_scan(m, "scan_rand");
        end
        test_first_pass_random(3);
        test_midrun_reset();
        test_lock_loss();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
